regfile_hilo: RTL and testbench
===============================

REGFILE_HILO -- requirements
Module: regfile_hilo

Interface
REQ-001 SHALL have port: clk  input  1  rising-edge clock for all state.
REQ-002 SHALL have port: rst  input  1  reset; synchronous, active-high.
REQ-003 SHALL have port: we  input  1  GPR write enable, from writeback wb_wreg.
REQ-004 SHALL have port: waddr  input  5  GPR write address, from wb_wd.
REQ-005 SHALL have port: wdata  input  32  GPR write data, from wb_wdata.
REQ-006 SHALL have port: re1 / re2  input  1 each  read-port enables.
REQ-007 SHALL have port: raddr1 / raddr2  input  5 each  read addresses.
REQ-008 SHALL have port: rdata1 / rdata2  output  32 each  read data, combinational.
REQ-009 SHALL have port: whilo  input  1  HI/LO write enable, from wb_whilo.
REQ-010 SHALL have port: hi_i / lo_i  input  32 each  HI/LO write data, from wb_hi / wb_lo.
REQ-011 SHALL have port: hi_o / lo_o  output  32 each  current HI/LO, combinational.
REQ-012 SHALL have port: wr_count  output  32  saturating count of committed GPR writes.

Function
REQ-013 SHALL hold 31 writable 32-bit GPRs, addresses 1..31; address 0 reads 0 and ignores writes.
REQ-014 SHALL commit a GPR write on the clk edge when we=1, waddr!=0 and rst=0; the value is visible on reads from the next cycle.
REQ-015 SHALL drive rdataN = 0 when reN=0, raddrN=0, or rst=1.
REQ-016 SHALL drive rdataN = GPR[raddrN] otherwise, subject to REQ-025.
REQ-017 SHALL let both read ports address the same register simultaneously and return identical data.
REQ-018 SHALL update HI and LO together on the clk edge when whilo=1 and rst=0; never one without the other.
REQ-019 SHALL drive hi_o/lo_o = 0 while rst=1, else stored HI/LO, subject to REQ-026.
REQ-020 SHALL increment wr_count by 1 each cycle a GPR write commits (REQ-014); writes to $0 not counted.
REQ-021 SHALL saturate wr_count at 0xFFFF_FFFF; it never wraps to 0.
REQ-022 SHALL treat GPR and HI/LO writes in the same cycle as independent; both commit.

Reset
REQ-023 SHALL, on a clk edge with rst=1, clear all GPRs, HI, LO and wr_count to 0 and discard any concurrent write.
REQ-024 SHALL, on rst asserted mid-stream, drop the write presented in that cycle; the first write after release commits normally.

Configuration
REQ-025 SHALL, with REGFILE_BYPASS_EN defined, return wdata on rdataN when reN=1, we=1, raddrN=waddr!=0 and rst=0 (same-cycle forwarding); without it, return the stored pre-write value.
REQ-026 SHALL, with REGFILE_BYPASS_EN defined, drive hi_o/lo_o = hi_i/lo_i when whilo=1 and rst=0; without it, drive stored values.

Structure
REQ-027 SHALL take RegBus, RegAddrBus, RegNum, ZeroWord, NOPRegAddr, WriteEnable/Disable, ReadEnable/Disable and RstEnable from the shared defines package.
REQ-028 SHALL instantiate one sub-module, hilo_reg, holding HI/LO and their bypass; GPR array and counter in the top.

Verification
REQ-029 SHALL pass: write 0x1234_5678 to $5, next cycle read $5 on port 1 -> rdata1=0x1234_5678, wr_count=1.
REQ-030 SHALL pass: write 0xFFFF_FFFF to $0, read $0 on both ports -> rdata1=rdata2=0, wr_count unchanged.
REQ-031 SHALL pass: $7=0xA, same cycle we=1 waddr=7 wdata=0xB, read raddr1=7 -> rdata1=0xB with REGFILE_BYPASS_EN, 0xA without.
REQ-032 SHALL pass: whilo=1 hi_i=0x1 lo_i=0x2 with we=1 to $3 -> next cycle hi_o=0x1, lo_o=0x2, $3 updated.
REQ-033 SHALL pass: rst=1 for one cycle while we=1 waddr=9 -> all reads 0, wr_count=0, $9 stays 0 after release.
REQ-034 SHALL pass: preload wr_count to 0xFFFF_FFFE, three writes -> wr_count holds 0xFFFF_FFFF.

Source files
------------

// File: rtl/regfile_hilo_pkg.sv
// regfile_hilo_pkg: shared register-file widths, enable encodings and helpers.
package regfile_hilo_pkg;

    localparam int RegBus     = 32;
    localparam int RegAddrBus = 5;
    localparam int RegNum     = 32;

    typedef logic [RegBus-1:0]     reg_t;
    typedef logic [RegAddrBus-1:0] addr_t;

    localparam reg_t  ZeroWord      = '0;
    localparam addr_t NOPRegAddr    = '0;
    localparam logic  WriteEnable   = 1'b1;
    localparam logic  WriteDisable  = 1'b0;
    localparam logic  ReadEnable    = 1'b1;
    localparam logic  ReadDisable   = 1'b0;
    localparam logic  RstEnable     = 1'b1;
    localparam reg_t  CountMax      = '1;

    // Counter increment that sticks at all-ones instead of wrapping.
    function automatic reg_t sat_inc(reg_t v);
        return (v == CountMax) ? v : v + reg_t'(1);
    endfunction

endpackage

// File: rtl/regfile_hilo_if.sv
// regfile_hilo_if: writeback/read bus between pipeline and register file.
interface regfile_hilo_if;
    import regfile_hilo_pkg::*;

    logic  we;
    addr_t waddr;
    reg_t  wdata;
    logic  re1;
    addr_t raddr1;
    reg_t  rdata1;
    logic  re2;
    addr_t raddr2;
    reg_t  rdata2;
    logic  whilo;
    reg_t  hi_i;
    reg_t  lo_i;
    reg_t  hi_o;
    reg_t  lo_o;
    reg_t  wr_count;

    modport master (
        output we, waddr, wdata, re1, raddr1, re2, raddr2, whilo, hi_i, lo_i,
        input  rdata1, rdata2, hi_o, lo_o, wr_count
    );

    modport slave (
        input  we, waddr, wdata, re1, raddr1, re2, raddr2, whilo, hi_i, lo_i,
        output rdata1, rdata2, hi_o, lo_o, wr_count
    );

endinterface

// File: rtl/hilo_reg.sv
// hilo_reg: paired HI/LO registers, always written together.
// Same-cycle forwarding of hi_i/lo_i is enabled by REGFILE_BYPASS_EN.
module hilo_reg
    import regfile_hilo_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic we_i,
    input  reg_t hi_i,
    input  reg_t lo_i,
    output reg_t hi_o,
    output reg_t lo_o
);

    reg_t hi_q, hi_d;
    reg_t lo_q, lo_d;
    logic fwd;

    always_comb begin
        hi_d = (we_i == WriteEnable) ? hi_i : hi_q;
        lo_d = (we_i == WriteEnable) ? lo_i : lo_q;
    end

    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            hi_q <= ZeroWord;
            lo_q <= ZeroWord;
        end else begin
            hi_q <= hi_d;
            lo_q <= lo_d;
        end
    end

`ifdef REGFILE_BYPASS_EN
    assign fwd = (we_i == WriteEnable);
`else
    assign fwd = 1'b0;
`endif

    always_comb begin
        hi_o = (rst == RstEnable) ? ZeroWord : fwd ? hi_i : hi_q;
        lo_o = (rst == RstEnable) ? ZeroWord : fwd ? lo_i : lo_q;
    end

endmodule

// File: rtl/regfile_hilo.sv
// regfile_hilo: 31-entry GPR file with $0 hardwired, HI/LO pair and write counter.
// REGFILE_BYPASS_EN forwards same-cycle write data to the read ports.
module regfile_hilo
    import regfile_hilo_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    regfile_hilo_if.slave  bus
);

    reg_t gpr_q [1:RegNum-1];
    reg_t wr_count_q, wr_count_d;
    logic commit;
    logic fwd1, fwd2;

    assign commit = (bus.we == WriteEnable) && (bus.waddr != NOPRegAddr) && (rst != RstEnable);

    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            for (int i = 1; i < RegNum; i++) gpr_q[i] <= ZeroWord;
        end else if (commit) begin
            gpr_q[bus.waddr] <= bus.wdata;
        end
    end

    assign wr_count_d = commit ? sat_inc(wr_count_q) : wr_count_q;

    always_ff @(posedge clk) begin
        if (rst == RstEnable) wr_count_q <= ZeroWord;
        else                  wr_count_q <= wr_count_d;
    end

    assign bus.wr_count = wr_count_q;

`ifdef REGFILE_BYPASS_EN
    assign fwd1 = commit && (bus.raddr1 == bus.waddr);
    assign fwd2 = commit && (bus.raddr2 == bus.waddr);
`else
    assign fwd1 = 1'b0;
    assign fwd2 = 1'b0;
`endif

    always_comb begin
        bus.rdata1 = (rst == RstEnable || bus.re1 == ReadDisable || bus.raddr1 == NOPRegAddr) ? ZeroWord
                   : fwd1 ? bus.wdata : gpr_q[bus.raddr1];
        bus.rdata2 = (rst == RstEnable || bus.re2 == ReadDisable || bus.raddr2 == NOPRegAddr) ? ZeroWord
                   : fwd2 ? bus.wdata : gpr_q[bus.raddr2];
    end

    hilo_reg u_hilo (
        .clk  (clk),
        .rst  (rst),
        .we_i (bus.whilo),
        .hi_i (bus.hi_i),
        .lo_i (bus.lo_i),
        .hi_o (bus.hi_o),
        .lo_o (bus.lo_o)
    );

endmodule

// File: tb/tb_regfile_hilo.sv
// tb_regfile_hilo: directed vectors with a queue scoreboard checked at negedge.
module tb_regfile_hilo;
    import regfile_hilo_pkg::*;

    typedef struct {
        string      n;
        int         s;
        logic [31:0] v;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    exp_t q[$];
    int   total = 0;
    int   passed = 0;

    regfile_hilo_if bus();

    regfile_hilo dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic gpr(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                       input logic r1, input logic [4:0] a1, input logic r2, input logic [4:0] a2);
        bus.we = we; bus.waddr = wa; bus.wdata = wd;
        bus.re1 = r1; bus.raddr1 = a1; bus.re2 = r2; bus.raddr2 = a2;
    endtask

    task automatic hilo(input logic w, input logic [31:0] h, input logic [31:0] l);
        bus.whilo = w; bus.hi_i = h; bus.lo_i = l;
    endtask

    task automatic expect_v(input string n, input int s, input logic [31:0] v);
        exp_t e;
        e.n = n; e.s = s; e.v = v;
        q.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: outputs are combinational, so they are valid every negedge.
    always @(negedge clk) begin
        while (q.size() > 0) begin
            exp_t e;
            logic [31:0] a;
            e = q.pop_front();
            a = (e.s == 0) ? bus.rdata1 : (e.s == 1) ? bus.rdata2 : (e.s == 2) ? bus.hi_o
              : (e.s == 3) ? bus.lo_o : bus.wr_count;
            total++;
            if (a !== e.v) $display("FAIL %s: got %h expected %h", e.n, a, e.v);
            else passed++;
        end
    end

    initial begin
        gpr(1, 9, 32'h99, 1, 5, 1, 9);
        hilo(1, 32'h5, 32'h6);
        step();
        expect_v("rst_rdata1", 0, 0);
        expect_v("rst_rdata2", 1, 0);
        expect_v("rst_hi", 2, 0);
        expect_v("rst_lo", 3, 0);
        expect_v("rst_count", 4, 0);
        step();
        rst = 1'b0;
        gpr(0, 0, 0, 1, 9, 0, 0);
        hilo(0, 0, 0);
        expect_v("post_rst_r9", 0, 0);
        expect_v("post_rst_count", 4, 0);
        expect_v("post_rst_hi", 2, 0);
        step();
        gpr(1, 5, 32'h1234_5678, 0, 0, 0, 0);
        expect_v("w5_count_before", 4, 0);
        step();
        gpr(0, 0, 0, 1, 5, 0, 0);
        expect_v("r5", 0, 32'h1234_5678);
        expect_v("w5_count", 4, 1);
        step();
        gpr(1, 0, 32'hFFFF_FFFF, 1, 0, 1, 0);
        expect_v("w0_same_r1", 0, 0);
        expect_v("w0_same_r2", 1, 0);
        step();
        gpr(0, 0, 0, 1, 0, 1, 0);
        expect_v("r0_p1", 0, 0);
        expect_v("r0_p2", 1, 0);
        expect_v("w0_count", 4, 1);
        step();
        gpr(1, 7, 32'hA, 0, 0, 0, 0);
        step();
        gpr(1, 7, 32'hB, 1, 7, 0, 0);
`ifdef REGFILE_BYPASS_EN
        expect_v("r7_same_cycle", 0, 32'hB);
`else
        expect_v("r7_same_cycle", 0, 32'hA);
`endif
        expect_v("w7_count", 4, 2);
        step();
        gpr(0, 0, 0, 1, 7, 1, 7);
        expect_v("r7_p1", 0, 32'hB);
        expect_v("r7_p2", 1, 32'hB);
        expect_v("w7b_count", 4, 3);
        step();
        gpr(0, 0, 0, 0, 7, 1, 5);
        expect_v("re1_off", 0, 0);
        expect_v("r5_p2", 1, 32'h1234_5678);
        step();
        gpr(1, 3, 32'h33, 0, 0, 0, 0);
        hilo(1, 32'h1, 32'h2);
`ifdef REGFILE_BYPASS_EN
        expect_v("hi_same_cycle", 2, 32'h1);
        expect_v("lo_same_cycle", 3, 32'h2);
`else
        expect_v("hi_same_cycle", 2, 0);
        expect_v("lo_same_cycle", 3, 0);
`endif
        step();
        gpr(0, 0, 0, 0, 0, 1, 3);
        hilo(0, 32'hDEAD, 32'hBEEF);
        expect_v("hi", 2, 32'h1);
        expect_v("lo", 3, 32'h2);
        expect_v("r3", 1, 32'h33);
        expect_v("w3_count", 4, 4);
        step();
        rst = 1'b1;
        gpr(1, 9, 32'h99, 1, 5, 1, 9);
        hilo(1, 32'h7, 32'h8);
        expect_v("mid_rst_r5", 0, 0);
        expect_v("mid_rst_r9", 1, 0);
        expect_v("mid_rst_hi", 2, 0);
        expect_v("mid_rst_lo", 3, 0);
        step();
        rst = 1'b0;
        gpr(1, 9, 32'h77, 1, 5, 0, 0);
        hilo(0, 0, 0);
        expect_v("after_rst_r5", 0, 0);
        expect_v("after_rst_count", 4, 0);
        expect_v("after_rst_hi", 2, 0);
        expect_v("after_rst_lo", 3, 0);
        step();
        gpr(0, 0, 0, 1, 9, 1, 3);
        expect_v("r9_after_rst", 0, 32'h77);
        expect_v("r3_cleared", 1, 0);
        expect_v("first_wr_count", 4, 1);
        step();
        force dut.wr_count_q = 32'hFFFF_FFFE;
        #1;
        release dut.wr_count_q;
        gpr(1, 1, 32'h1, 0, 0, 0, 0);
        expect_v("sat_preload", 4, 32'hFFFF_FFFE);
        step();
        gpr(1, 2, 32'h2, 0, 0, 0, 0);
        expect_v("sat_1", 4, 32'hFFFF_FFFF);
        step();
        gpr(1, 4, 32'h4, 0, 0, 0, 0);
        expect_v("sat_2", 4, 32'hFFFF_FFFF);
        step();
        gpr(0, 0, 0, 1, 4, 0, 0);
        expect_v("sat_3", 4, 32'hFFFF_FFFF);
        expect_v("r4", 0, 32'h4);
        step();
        for (int i = 0; i < 5 && q.size() > 0; i++) @(negedge clk);
        if (q.size() > 0) begin
            $display("FAIL drain: got %0d pending expected 0", q.size());
            total++;
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
